// File: rtl/keyb_scanner_pkg.sv
// Shared types, sizes and small helpers for the 4x4 keypad scanner.
package keyb_scanner_pkg;

    localparam int IDX_W    = 2;
    localparam int KEYPAD_N = 4;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Index of the lowest-numbered column pulled low (0 when none is low).
    function automatic logic [IDX_W-1:0] lowest_low(input logic [KEYPAD_N-1:0] cols);
        lowest_low = {IDX_W{1'b0}};
        for (int i = KEYPAD_N - 1; i >= 0; i--) begin
            if (!cols[i]) begin
                lowest_low = IDX_W'(i);
            end
        end
    endfunction

    function automatic logic [KEYPAD_N-1:0] row_drive(input logic [IDX_W-1:0] r);
        row_drive = ~(4'b0001 << r);
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Free-running row-slot counter; tick marks the last cycle of every slot.
module scan_timer #(
    parameter int SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);

    logic [15:0] cnt;

    // Slot counter wraps after SCAN_DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 16'd0;
        end else if (cnt == LAST) begin
            cnt <= 16'd0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/keyb_scanner.sv
// 4x4 matrix keypad scanner with per-tick debounce of both press and release.
module keyb_scanner
    import keyb_scanner_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cols_n,
    output logic [3:0] rows_n,
    output logic       D0,
    output logic       D1,
    output logic       Q0,
    output logic       Q1,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [7:0] DB = 8'(DEBOUNCE_CNT);

    logic [KEYPAD_N-1:0] cols_meta;
    logic [KEYPAD_N-1:0] cols_sync;
    state_t              state;
    logic [IDX_W-1:0]    row_idx;
    logic [IDX_W-1:0]    col_idx;
    logic [IDX_W-1:0]    d_idx;
    logic [IDX_W-1:0]    q_idx;
    logic [7:0]          match_cnt;
    logic                tick;
    logic                any_low;
    logic [IDX_W-1:0]    low_col;
    logic [IDX_W-1:0]    next_row;

    scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign any_low  = ~&cols_sync;
    assign low_col  = lowest_low(cols_sync);
    assign next_row = row_idx + 2'd1;

    assign D0 = d_idx[0];
    assign D1 = d_idx[1];
    assign Q0 = q_idx[0];
    assign Q1 = q_idx[1];

    // Two-flop synchronizer for the asynchronous column lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cols_meta <= 4'b0000;
            cols_sync <= 4'b0000;
        end else begin
            cols_meta <= cols_n;
            cols_sync <= cols_meta;
        end
    end

    // Scan/debounce state machine; only tick cycles move it, key_valid self-clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_SCAN;
            row_idx   <= 2'd0;
            col_idx   <= 2'd0;
            d_idx     <= 2'd0;
            q_idx     <= 2'd0;
            match_cnt <= 8'd0;
            rows_n    <= 4'b1110;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    ST_SCAN: begin
                        if (any_low) begin
                            col_idx <= low_col;
                            if (DB == 8'd1) begin
                                d_idx     <= row_idx;
                                q_idx     <= low_col;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                state     <= ST_PRESSED;
                            end else begin
                                match_cnt <= 8'd1;
                                state     <= ST_DEBOUNCE;
                            end
                        end else begin
                            row_idx <= next_row;
                            rows_n  <= row_drive(next_row);
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (any_low && (low_col == col_idx)) begin
                            if (match_cnt + 8'd1 == DB) begin
                                d_idx     <= row_idx;
                                q_idx     <= col_idx;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                state     <= ST_PRESSED;
                            end else begin
                                match_cnt <= match_cnt + 8'd1;
                            end
                        end else begin
                            row_idx <= next_row;
                            rows_n  <= row_drive(next_row);
                            state   <= ST_SCAN;
                        end
                    end
                    ST_PRESSED: begin
                        // The first quiet tick already counts toward the release.
                        if (!any_low) begin
                            if (DB == 8'd1) begin
                                key_held <= 1'b0;
                                row_idx  <= next_row;
                                rows_n   <= row_drive(next_row);
                                state    <= ST_SCAN;
                            end else begin
                                match_cnt <= 8'd1;
                                state     <= ST_RELEASE;
                            end
                        end
                    end
                    ST_RELEASE: begin
                        if (any_low) begin
                            state <= ST_PRESSED;
                        end else if (match_cnt + 8'd1 == DB) begin
                            key_held <= 1'b0;
                            row_idx  <= next_row;
                            rows_n   <= row_drive(next_row);
                            state    <= ST_SCAN;
                        end else begin
                            match_cnt <= match_cnt + 8'd1;
                        end
                    end
                    default: begin
                        state <= ST_SCAN;
                    end
                endcase
            end
        end
    end

endmodule
